// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state codes,
// MIPS opcode values, instruction field bit positions and the PC step.
package ifu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t FETCH  = 2'd1;
  localparam state_t DECODE = 2'd2;
  localparam state_t EXEC   = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Word-aligned branch offset: sign-extended immediate shifted left by two.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_pc_calc.sv
// Combinational next-PC: PC + 4, plus the word-aligned beq offset when taken.
// All arithmetic wraps modulo 2^32.
module ifu_pc_calc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic        take,
  output logic [31:0] next_pc
);

  logic [31:0] offset_s;

  // Select the branch offset and form the sequential or branch target.
  always_comb begin
    offset_s = 32'd0;
    if (take) begin
      offset_s = branch_offset(imm);
    end else begin
      offset_s = 32'd0;
    end
    next_pc = pc + PC_STEP + offset_s;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, imem req/valid handshake, IR, beq resolution.
// Define IFU_TIMEOUT_EN to add the FETCH timeout counter and sticky fetch_err_o.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IFU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        zero_i,
  output logic [31:0] pc_o,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm_o,
  output logic        instr_valid_o,
  output logic        fetch_err_o
);

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] ir_r;
  logic [31:0] next_pc_s;
  logic        captured_r;
  logic        capture_s;
  logic        take_s;
  logic        req_r;
  logic        valid_r;

  // A word taken during a stalled FETCH is held; later strobes in that FETCH are ignored.
  assign capture_s = (state_r == FETCH) && imem_valid && !captured_r;
  assign take_s    = branch_i & zero_i;

  ifu_pc_calc u_pc_calc (
    .pc      (pc_r),
    .imm     (ir_r[IMM_HI:IMM_LO]),
    .take    (take_s),
    .next_pc (next_pc_s)
  );

  // Next-state selection; a stall freezes the current state.
  always_comb begin
    state_next_s = state_r;
    if (stall_i) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        IDLE:    state_next_s = FETCH;
        FETCH: begin
          if (imem_valid || captured_r) begin
            state_next_s = DECODE;
          end else begin
            state_next_s = FETCH;
          end
        end
        DECODE:  state_next_s = EXEC;
        EXEC:    state_next_s = FETCH;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State, PC, IR and the registered handshake/valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      ir_r       <= 32'd0;
      captured_r <= 1'b0;
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      req_r   <= (state_next_s == FETCH);
      valid_r <= (state_next_s == DECODE);
      if (capture_s) begin
        ir_r <= imem_rdata;
      end
      if (state_r == FETCH && stall_i) begin
        captured_r <= captured_r | imem_valid;
      end else begin
        captured_r <= 1'b0;
      end
      if (state_r == EXEC && !stall_i) begin
        pc_r <= next_pc_s;
      end
    end
  end

`ifdef IFU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt_r;
  logic             err_r;

  // Count unanswered FETCH cycles; on expiry flag the error and keep requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else if (state_r != FETCH) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_i || imem_valid || captured_r) begin
      wait_cnt_r <= wait_cnt_r;
    end else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      wait_cnt_r <= {CNT_W{1'b0}};
      err_r      <= 1'b1;
    end else begin
      wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign fetch_err_o = err_r;
`else
  assign fetch_err_o = 1'b0;
`endif

  assign imem_req      = req_r;
  assign imem_addr     = pc_r;
  assign pc_o          = pc_r;
  assign instr_valid_o = valid_r;
  assign opcode_o      = ir_r[OPCODE_HI:OPCODE_LO];
  assign rs_o          = ir_r[RS_HI:RS_LO];
  assign rt_o          = ir_r[RT_HI:RT_LO];
  assign rd_o          = ir_r[RD_HI:RD_LO];
  assign funct_o       = ir_r[FUNCT_HI:FUNCT_LO];
  assign imm_o         = ir_r[IMM_HI:IMM_LO];

endmodule
